// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        DATA,
        WRITE,
        CHK,
        DONE
    } state_t;

    localparam int HDR_BYTES  = 2;
    localparam int WORD_BYTES = 4;
    localparam int INSTR_W    = 32;
    localparam int BYTE_CNT_W = 2;

endpackage

// File: rtl/imem_loader_byte_assembler.sv
// Big-endian byte-to-word shift register; word_full pulses for the one cycle
// after the byte that completes a word.
module byte_assembler
    import imem_loader_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  shift_en,
    input  logic [7:0]            in_byte,
    output logic [INSTR_W-1:0]    word,
    output logic [BYTE_CNT_W-1:0] byte_cnt,
    output logic                  word_full
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word      <= '0;
            byte_cnt  <= '0;
            word_full <= 1'b0;
        end else if (clear) begin
            word      <= '0;
            byte_cnt  <= '0;
            word_full <= 1'b0;
        end else begin
            word_full <= shift_en && (byte_cnt == BYTE_CNT_W'(WORD_BYTES - 1));
            if (shift_en) begin
                word     <= {word[INSTR_W-9:0], in_byte};
                byte_cnt <= byte_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Streams a checksummed program into instruction memory and holds the core
// stalled until a verified image is resident.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [7:0]         in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               imem_we,
    output logic [ADDR_W-1:0]  imem_addr,
    output logic [INSTR_W-1:0] imem_wdata,
    output logic               cpu_hold,
    output logic               done,
    output logic               err
);

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

    state_t                  state;
    logic [7:0]              hdr_hi;
    logic                    hdr_cnt;
    logic [ADDR_W-1:0]       last_idx;
    logic [ADDR_W-1:0]       wcnt;
    logic [7:0]              chk;
    logic                    xfer;
    logic                    restart;
    logic                    asm_shift;
    logic                    asm_full;
    logic [BYTE_CNT_W-1:0]   asm_cnt;

    // The assembler's full pulse coincides with WRITE, blocking the stream there.
    assign in_ready  = (state == HDR) || (state == CHK) || ((state == DATA) && !asm_full);
    assign xfer      = in_valid && in_ready;
    assign restart   = start && ((state == IDLE) || (state == DONE));
    assign asm_shift = xfer && (state == DATA);

    byte_assembler u_asm (
        .clk       (clk),
        .rst       (rst),
        .clear     (restart),
        .shift_en  (asm_shift),
        .in_byte   (in_data),
        .word      (imem_wdata),
        .byte_cnt  (asm_cnt),
        .word_full (asm_full)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            imem_we   <= 1'b0;
            imem_addr <= BASE;
            cpu_hold  <= 1'b1;
            done      <= 1'b0;
            err       <= 1'b0;
            hdr_hi    <= '0;
            hdr_cnt   <= 1'b0;
            last_idx  <= '0;
            wcnt      <= '0;
            chk       <= '0;
        end else begin
            imem_we <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (restart) begin
                        state     <= HDR;
                        cpu_hold  <= 1'b1;
                        done      <= 1'b0;
                        err       <= 1'b0;
                        hdr_cnt   <= 1'b0;
                        chk       <= '0;
                        wcnt      <= '0;
                        imem_addr <= BASE;
                    end
                end
                HDR: begin
                    if (xfer) begin
                        if (hdr_cnt == 1'(HDR_BYTES - 1)) begin
                            // Header carries N-1, so an all-ones field means a full memory.
                            last_idx <= ADDR_W'({hdr_hi, in_data});
                            state    <= DATA;
                        end else begin
                            hdr_hi  <= in_data;
                            hdr_cnt <= 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (xfer) begin
                        chk <= chk ^ in_data;
                        if (asm_cnt == BYTE_CNT_W'(WORD_BYTES - 1)) begin
                            imem_we <= 1'b1;
                            state   <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    imem_addr <= imem_addr + 1'b1;
                    if (wcnt == last_idx) begin
                        state <= CHK;
                    end else begin
                        wcnt  <= wcnt + 1'b1;
                        state <= DATA;
                    end
                end
                CHK: begin
                    if (xfer) begin
                        done  <= 1'b1;
                        state <= DONE;
                        if (in_data == chk) begin
                            cpu_hold <= 1'b0;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a BASE_ADDR=0 and a BASE_ADDR=1022 instance
// share one stimulus stream.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;

    logic        rdy0, we0, hold0, done0, err0;
    logic [9:0]  addr0;
    logic [31:0] wdata0;
    logic        rdy1, we1, hold1, done1, err1;
    logic [9:0]  addr1;
    logic [31:0] wdata1;

    int checks = 0;
    int errors = 0;
    int wr0 = 0;
    int wr1 = 0;

    always #5 clk = ~clk;

    imem_loader #(.ADDR_W(10), .BASE_ADDR(0)) u0 (
        .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy0), .imem_we(we0), .imem_addr(addr0), .imem_wdata(wdata0),
        .cpu_hold(hold0), .done(done0), .err(err0)
    );

    imem_loader #(.ADDR_W(10), .BASE_ADDR(1022)) u1 (
        .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy1), .imem_we(we1), .imem_addr(addr1), .imem_wdata(wdata1),
        .cpu_hold(hold1), .done(done1), .err(err1)
    );

    always @(negedge clk) begin
        if (we0) wr0 <= wr0 + 1;
        if (we1) wr1 <= wr1 + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit ok;
        ok = 1'b0;
        @(posedge clk); #1;
        repeat (gap) begin
            @(posedge clk); #1;
        end
        in_data  = b;
        in_valid = 1'b1;
        for (int n = 0; n < 40; n++) begin
            if (rdy0) begin
                @(posedge clk); #1;
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("handshake", 32'(ok), 32'd1);
    endtask

    // Sends one word and checks the write appears in the very next cycle.
    task automatic send_word(input logic [31:0] w, input int max_gap,
                             input logic [9:0] ea0, input logic [9:0] ea1);
        logic [31:0] tmp;
        tmp = w;
        for (int i = 3; i >= 0; i--)
            send_byte(tmp[i*8 +: 8], $urandom_range(0, max_gap));
        @(negedge clk);
        check("we0", 32'(we0), 32'd1);
        check("we1", 32'(we1), 32'd1);
        check("ready_on_write", 32'(rdy0), 32'd0);
        check("addr0", 32'(addr0), 32'(ea0));
        check("wdata0", wdata0, w);
        check("addr1", 32'(addr1), 32'(ea1));
        check("wdata1", wdata1, w);
    endtask

    task automatic check_end(input logic exp_err, input int exp_wr);
        @(negedge clk);
        check("done", 32'(done0), 32'd1);
        check("err", 32'(err0), 32'(exp_err));
        check("cpu_hold", 32'(hold0), 32'(exp_err));
        check("ready_done", 32'(rdy0), 32'd0);
        check("wr_count0", 32'(wr0), 32'(exp_wr));
        check("wr_count1", 32'(wr1), 32'(exp_wr));
    endtask

    initial begin
        #2 rst = 1'b1;
        #1;
        check("rst_hold", 32'(hold0), 32'd1);
        check("rst_done", 32'(done0), 32'd0);
        check("rst_err", 32'(err0), 32'd0);
        check("rst_ready", 32'(rdy0), 32'd0);
        check("rst_we", 32'(we0), 32'd0);
        check("rst_addr0", 32'(addr0), 32'd0);
        check("rst_addr1", 32'(addr1), 32'd1022);
        check("rst_wdata", wdata0, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Idle without start: nothing moves.
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("idle_ready", 32'(rdy0), 32'd0);
        check("idle_hold", 32'(hold0), 32'd1);
        check("idle_done", 32'(done0), 32'd0);
        check("idle_writes", 32'(wr0), 32'd0);

        // Single word, no stalls.
        pulse_start();
        check("hdr_ready", 32'(rdy0), 32'd1);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_word(32'h00440010, 0, 10'd0, 10'd1022);
        send_byte(8'h54, 0);
        check_end(1'b0, 1);

        // Three words with random valid gaps; checksum C0.
        pulse_start();
        send_byte(8'h00, 1);
        send_byte(8'h02, 2);
        send_word(32'h8C480004, 3, 10'd0, 10'd1022);
        send_word(32'h10000010, 3, 10'd1, 10'd1023);
        send_word(32'hFFFFFFFF, 3, 10'd2, 10'd0);
        send_byte(8'hC0, 3);
        check_end(1'b0, 4);

        // Bad checksum (54 expected, 55 sent).
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_word(32'h00440010, 0, 10'd0, 10'd1022);
        send_byte(8'h55, 0);
        check_end(1'b1, 5);
        pulse_start();
        check("restart_done", 32'(done0), 32'd0);
        check("restart_err", 32'(err0), 32'd0);
        check("restart_hold", 32'(hold0), 32'd1);
        check("restart_ready", 32'(rdy0), 32'd1);

        // Four words: the 1022 instance wraps through 1023 to 0 and 1; checksum 2B.
        send_byte(8'h00, 0);
        send_byte(8'h03, 0);
        send_word(32'h00000001, 1, 10'd0, 10'd1022);
        send_word(32'h12345678, 1, 10'd1, 10'd1023);
        send_word(32'hDEADBEEF, 1, 10'd2, 10'd0);
        send_word(32'hA5A5A5A5, 1, 10'd3, 10'd1);
        send_byte(8'h2B, 0);
        check_end(1'b0, 9);

        // Reset after two bytes of the second word.
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_word(32'hCAFEF00D, 0, 10'd0, 10'd1022);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        rst = 1'b1;
        #1;
        check("midrst_hold", 32'(hold0), 32'd1);
        check("midrst_we", 32'(we0), 32'd0);
        check("midrst_ready", 32'(rdy0), 32'd0);
        check("midrst_addr", 32'(addr0), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        in_data  = 8'h33;
        in_valid = 1'b1;
        repeat (4) @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check("midrst_writes", 32'(wr0), 32'd10);
        check("midrst_idle_ready", 32'(rdy0), 32'd0);

        // Clean reload; start pulses mid-load must be ignored.
        pulse_start();
        send_byte(8'h00, 0);
        pulse_start();
        check("ign_hdr_ready", 32'(rdy0), 32'd1);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_byte(8'h44, 0);
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h10, 0);
        @(negedge clk);
        check("reload_we", 32'(we0), 32'd1);
        check("reload_addr0", 32'(addr0), 32'd0);
        check("reload_wdata", wdata0, 32'h00440010);
        check("reload_addr1", 32'(addr1), 32'd1022);
        send_byte(8'h54, 0);
        check_end(1'b0, 11);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
